// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock-qualified system reset sequencer
// Runs on the reference clock so it keeps sequencing while the PLL outputs are dead.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_STABLE    = 1024,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int RESET_HOLD     = 64,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       locked,
   input  logic       sw_reset_req,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] lock_loss_count,
   output logic [7:0] retry_count
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'b00,
      ST_WAIT_LOCK = 2'b01,
      ST_HOLD      = 2'b10,
      ST_RUN       = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [7:0]       loss_q, loss_d;
   logic [7:0]       retry_q, retry_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_reset_q, sys_reset_d;
   logic             ready_q, ready_d;
   logic             locked_s;

   assign locked_s = sync2_q;

   // cnt_q is the per-state counter: PLL reset length, stable-lock run, hold length
   always_comb begin
      sync1_d = locked;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      loss_d  = loss_q;
      retry_d = retry_q;
      case (state_q)
         ST_PLL_RST: begin
            if (cnt_q == PLL_RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s && cnt_q == STABLE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_PLL_RST;
               cnt_d   = '0;
               tmo_d   = '0;
               if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end else begin
               cnt_d = locked_s ? cnt_q + CNT_W'(1) : '0;
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               tmo_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               tmo_d   = '0;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end else if (sw_reset_req) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            tmo_d   = '0;
         end
      endcase
      // Outputs are decoded from the next state so the registered copy tracks state_q.
      pll_rst_d   = (state_d == ST_PLL_RST);
      sys_reset_d = (state_d != ST_RUN);
      ready_d     = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         tmo_q       <= '0;
         loss_q      <= '0;
         retry_q     <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         loss_q      <= loss_d;
         retry_q     <= retry_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         pll_rst_q   <= pll_rst_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign sys_reset       = sys_reset_q;
   assign ready           = ready_q;
   assign state           = state_q;
   assign lock_loss_count = loss_q;
   assign retry_count     = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - bench for pll_reset_sequencer
// Directed scenarios plus random lock/sw_reset_req traffic against a cycle model.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LS  = 8;
   localparam int LT  = 32;
   localparam int RH  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       sw_reset_req = 1'b0;
   logic       pll_rst, sys_reset, ready;
   logic [1:0] state;
   logic [7:0] lock_loss_count, retry_count;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(PRC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .RESET_HOLD(RH), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked), .sw_reset_req(sw_reset_req),
      .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .state(state),
      .lock_loss_count(lock_loss_count), .retry_count(retry_count)
   );

   always #10 clk = ~clk;

   // Model: phase 0 PLL reset, 1 waiting for lock, 2 hold, 3 run; age = cycles in phase.
   int m_phase = 0;
   int m_age   = 0;
   int m_run   = 0;
   int m_loss  = 0;
   int m_retry = 0;
   bit lk_hist[$] = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_age = 0; m_run = 0; m_loss = 0; m_retry = 0;
         lk_hist = '{1'b0, 1'b0};
      end else begin
         bit ls;
         int nxt;
         ls = lk_hist.pop_front();
         lk_hist.push_back(locked);
         nxt = -1;
         case (m_phase)
            0: if (m_age + 1 == PRC) nxt = 1;
            1: begin
               m_run = ls ? m_run + 1 : 0;
               if (ls && m_run == LS) nxt = 2;
               else if (m_age + 1 == LT) begin
                  nxt = 0;
                  if (m_retry < 255) m_retry++;
               end
            end
            2: if (!ls) nxt = 1; else if (m_age + 1 == RH) nxt = 3;
            default: begin
               if (!ls) begin
                  nxt = 1;
                  if (m_loss < 255) m_loss++;
               end else if (sw_reset_req) nxt = 2;
            end
         endcase
         if (nxt >= 0) begin
            m_phase = nxt; m_age = 0; m_run = 0;
         end else m_age++;
      end
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         n_vec++;
         if (pll_rst !== (m_phase == 0) || sys_reset !== (m_phase != 3) ||
             ready !== (m_phase == 3) || state !== 2'(m_phase) ||
             lock_loss_count !== 8'(m_loss) || retry_count !== 8'(m_retry)) begin
            n_miss++;
            $display("FAIL cycle t=%0t: got st=%0d pr=%0b sr=%0b rdy=%0b loss=%0d rty=%0d expected st=%0d loss=%0d rty=%0d",
                     $time, state, pll_rst, sys_reset, ready, lock_loss_count, retry_count,
                     m_phase, m_loss, m_retry);
         end
      end
   endtask

   task automatic wait_state(input int s, input string nm);
      int n = 0;
      while (state != 2'(s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, state, s);
   endtask

   initial begin
      int n;
      int pll_seen;
      int loss0;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_sys_reset", sys_reset, 1);
      chk("rst_ready", ready, 0);
      chk("rst_state", state, 0);
      chk("rst_loss", lock_loss_count, 0);
      chk("rst_retry", retry_count, 0);

      // 1: PLL reset length and timeout
      rst = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (state == 2'd0 && n < 100);
      chk("pll_rst_edges", n, PRC);
      chk("after_pll_rst_state", state, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (state == 2'd1 && n < 100);
      chk("timeout_edges", n, LT);
      chk("timeout_state", state, 0);
      chk("retry_one", retry_count, 1);

      // 2: clean lock
      wait_state(1, "reach_wait");
      locked = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ready && n < 100);
      chk("lock_to_ready", n, 2 + LS + RH);
      chk("run_sys_reset", sys_reset, 0);

      // 4: one-cycle lock drop in RUN
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      n = 1;
      while (!sys_reset && n < 20) begin @(negedge clk); n++; end
      chk("loss_sys_reset_edge", n, 3);
      chk("loss_count_one", lock_loss_count, 1);
      chk("loss_state", state, 1);
      n = 0; pll_seen = 0;
      while (!ready && n < 100) begin
         @(negedge clk); n++;
         if (pll_rst) pll_seen = 1;
      end
      chk("relock_edges", n, LS + RH);
      chk("relock_no_pll_rst", pll_seen, 0);

      // 3: glitchy lock
      locked = 1'b0;
      wait_state(1, "glitch_wait");
      locked = 1'b1;
      repeat (6) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ready && n < 100);
      chk("glitch_to_ready", n, 2 + LS + RH);

      // 5: software reset, then software reset colliding with lock loss
      @(negedge clk);
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      chk("sw_state_hold", state, 2);
      n = 0;
      while (sys_reset && n < 50) begin n++; @(negedge clk); end
      chk("sw_hold_cycles", n, RH);
      chk("sw_back_run", state, 3);
      loss0 = lock_loss_count;
      locked = 1'b0;
      repeat (2) @(negedge clk);
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      chk("sw_vs_loss_state", state, 1);
      chk("sw_vs_loss_count", lock_loss_count, loss0 + 1);
      locked = 1'b1;
      wait_state(3, "sw_vs_loss_recover");

      // random traffic
      for (int seg = 0; seg < 150; seg++) begin
         int len;
         locked = 1'($urandom_range(0, 3) != 0);
         len = locked ? $urandom_range(1, 40) : $urandom_range(1, 45);
         for (int c = 0; c < len; c++) begin
            sw_reset_req = 1'($urandom_range(0, 15) == 0);
            @(negedge clk);
         end
      end
      sw_reset_req = 1'b0;

      // 6: retry saturation and asynchronous reset
      locked = 1'b0;
      repeat (300 * (PRC + LT) + 10) @(negedge clk);
      chk("retry_saturated", retry_count, 255);
      locked = 1'b1;
      wait_state(2, "reach_hold");
      #2 rst = 1'b1;
      #1;
      chk("async_pll_rst", pll_rst, 1);
      chk("async_sys_reset", sys_reset, 1);
      chk("async_ready", ready, 0);
      chk("async_state", state, 0);
      chk("async_loss", lock_loss_count, 0);
      chk("async_retry", retry_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_state(3, "post_rst_run");
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
